// File: rtl/ircam_div_ctrl.sv
// ircam_div_ctrl -- programmable clock divider controller.
//
// Produces a registered divided clock div_clk. Each level lasts cur_half+1
// clk cycles. The controller starts on the run level and stops cleanly when
// run is dropped: a high phase is always completed, so there is never a
// truncated high phase. A new terminal count can be offered at any time.
// It is applied immediately when idle. While running it is held in a
// one-entry pending slot and applied at the next falling edge of div_clk,
// which is the period boundary.
//
// Ports
//   clk        system clock, all state updates on its rising edge
//   rst_n      asynchronous active-low reset
//   run        level request: 1 = divide, 0 = stop at the next clean point
//   cfg_valid  a new half-period terminal count is offered on cfg_half
//   cfg_half   offered terminal count (toggle every cfg_half+1 cycles)
//   cfg_ready  pending slot is free, so an offer is accepted this cycle
//   div_clk    divided clock (registered)
//   rise_pls   one-cycle pulse in the first cycle div_clk reads 1
//   fall_pls   one-cycle pulse in the first cycle div_clk reads 0
//   busy       controller is in RUN or DRAIN
//   cur_half   terminal count currently in use
module ircam_div_ctrl #(
  parameter int CNT_W    = 4,
  parameter int DEF_HALF = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             div_clk,
  output logic             rise_pls,
  output logic             fall_pls,
  output logic             busy,
  output logic [CNT_W-1:0] cur_half
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_half;
  logic             pend_vld;

  logic tc;          // counter at terminal count: div_clk toggles on this edge
  logic accept;      // configuration handshake completes this cycle
  logic fall_now;    // div_clk goes 1->0 on this edge (period boundary)
  logic drain_exit;  // leaving DRAIN on this edge

  assign cfg_ready  = !pend_vld;
  assign tc         = (cnt == cur_half);
  assign accept     = cfg_valid && !pend_vld;
  assign fall_now   = tc && div_clk;
  // A high phase ends with its falling edge. A low phase simply stops at its
  // terminal count instead of starting another high phase.
  assign drain_exit = (state == DRAIN) && !run && tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      div_clk   <= 1'b0;
      rise_pls  <= 1'b0;
      fall_pls  <= 1'b0;
      busy      <= 1'b0;
      pend_vld  <= 1'b0;
      pend_half <= '0;
      cur_half  <= CNT_W'(DEF_HALF);
    end else begin
      rise_pls <= 1'b0;
      fall_pls <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          div_clk <= 1'b0;
          // Idle: no phase is in progress, so the new count applies at once.
          if (accept) cur_half <= cfg_half;
          if (run) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end

        RUN, DRAIN: begin
          if (drain_exit) begin
            state    <= IDLE;
            busy     <= 1'b0;
            cnt      <= '0;
            div_clk  <= 1'b0;
            fall_pls <= div_clk;
            pend_vld <= 1'b0;
            // A held value is applied on the way out. An offer accepted in
            // this same cycle is applied directly, so the pending slot is
            // never left occupied in IDLE.
            if (pend_vld)    cur_half <= pend_half;
            else if (accept) cur_half <= cfg_half;
          end else begin
            cnt <= tc ? '0 : cnt + CNT_W'(1);
            if (tc) begin
              div_clk  <= ~div_clk;
              rise_pls <= ~div_clk;
              fall_pls <= div_clk;
            end
            // The pending value is swapped in at the period boundary, which
            // is also where cnt returns to 0. The new count therefore covers
            // the whole next phase. An accept needs pend_vld == 0, so it
            // never coincides with the swap.
            if (fall_now && pend_vld) begin
              cur_half <= pend_half;
              pend_vld <= 1'b0;
            end else if (accept) begin
              pend_half <= cfg_half;
              pend_vld  <= 1'b1;
            end
            if (state == RUN && !run)      state <= DRAIN;
            else if (state == DRAIN && run) state <= RUN;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ircam_div_ctrl.sv
// Testbench for ircam_div_ctrl.
//
// Expected div_clk edges (kind, cycle, cur_half) are queued when a scenario
// is launched. A monitor pops the queue on every rise_pls/fall_pls and
// compares the entry against what it observes.
module tb_ircam_div_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             div_clk;
  logic             rise_pls;
  logic             fall_pls;
  logic             busy;
  logic [CNT_W-1:0] cur_half;

  ircam_div_ctrl #(.CNT_W(CNT_W), .DEF_HALF(14)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .cfg_valid(cfg_valid),
    .cfg_half (cfg_half),
    .cfg_ready(cfg_ready),
    .div_clk  (div_clk),
    .rise_pls (rise_pls),
    .fall_pls (fall_pls),
    .busy     (busy),
    .cur_half (cur_half)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    bit rise;
    int cyc;
    int half;
  } ev_t;

  ev_t sb[$];

  task automatic push(input bit rise, input int at, input int half);
    ev_t e;
    e.rise = rise;
    e.cyc  = at;
    e.half = half;
    sb.push_back(e);
  endtask

  // Bounded by construction: every negedge advances cyc.
  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rise_pls || fall_pls) begin
      if (sb.size() == 0) begin
        chk("unexp_pls", int'(rise_pls | fall_pls), 0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("pls_kind", int'(rise_pls), int'(e.rise));
        chk("pls_both", int'(rise_pls & fall_pls), 0);
        chk("pls_cyc",  cyc, e.cyc);
        chk("pls_half", int'(cur_half), e.half);
        chk("pls_lvl",  int'(div_clk), int'(e.rise));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int e;
    rst_n = 1'b0; run = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    repeat (3) @(negedge clk);
    chk("rst_div",   int'(div_clk), 0);
    chk("rst_rise",  int'(rise_pls), 0);
    chk("rst_fall",  int'(fall_pls), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_rdy",   int'(cfg_ready), 1);
    chk("rst_half",  int'(cur_half), 14);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // Default ratio: first rise 15 cycles after RUN entry, 30-cycle period.
    // Run is then dropped 2 cycles into a high phase; that phase still gets
    // its full 15 cycles.
    run = 1'b1;
    e = cyc + 1;
    push(1, e + 15, 14); push(0, e + 30, 14);
    push(1, e + 45, 14); push(0, e + 60, 14);
    push(1, e + 75, 14); push(0, e + 90, 14);
    wait_until(e);
    chk("run_busy", int'(busy), 1);
    wait_until(e + 76);
    run = 1'b0;
    wait_until(e + 89);
    chk("drain_busy", int'(busy), 1);
    chk("drain_hi",   int'(div_clk), 1);
    wait_until(e + 90);
    chk("stop_busy", int'(busy), 0);
    chk("stop_div",  int'(div_clk), 0);
    wait_until(e + 130);
    chk("sb_empty1", sb.size(), 0);

    // Run dropped and reasserted inside DRAIN: the period is unbroken. Then
    // half=3 is offered mid-high-phase and takes effect at the fall. A
    // second offer made while the first is pending is ignored.
    run = 1'b1;
    e = cyc + 1;
    push(1, e + 15, 14); push(0, e + 30, 14); push(1, e + 45, 14);
    push(0, e + 60, 3);  push(1, e + 64, 3);  push(0, e + 68, 3);
    push(1, e + 72, 3);  push(0, e + 76, 3);
    wait_until(e + 17);
    run = 1'b0;
    wait_until(e + 20);
    chk("redrain_busy", int'(busy), 1);
    run = 1'b1;
    wait_until(e + 50);
    chk("cfg_rdy_pre", int'(cfg_ready), 1);
    cfg_half = 4'd3; cfg_valid = 1'b1;
    wait_until(e + 51);
    cfg_valid = 1'b0;
    chk("cfg_rdy_pend", int'(cfg_ready), 0);
    chk("cfg_half_old", int'(cur_half), 14);
    wait_until(e + 52);
    cfg_half = 4'd7; cfg_valid = 1'b1;
    wait_until(e + 53);
    cfg_valid = 1'b0;
    chk("cfg_rdy_ign", int'(cfg_ready), 0);
    wait_until(e + 59);
    chk("cfg_half_hold", int'(cur_half), 14);
    wait_until(e + 60);
    chk("cfg_rdy_post", int'(cfg_ready), 1);
    chk("cfg_half_new", int'(cur_half), 3);
    wait_until(e + 73);
    run = 1'b0;
    wait_until(e + 90);
    chk("ign_half", int'(cur_half), 3);
    chk("stop2_busy", int'(busy), 0);
    chk("sb_empty2", sb.size(), 0);

    // Half=0 accepted in IDLE together with run: divide by 2.
    cfg_half = 4'd0; cfg_valid = 1'b1; run = 1'b1;
    e = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      push(1, e + 1 + 2 * k, 0);
      push(0, e + 2 + 2 * k, 0);
    end
    wait_until(e);
    cfg_valid = 1'b0;
    chk("div2_half", int'(cur_half), 0);
    chk("div2_rdy",  int'(cfg_ready), 1);
    wait_until(e + 6);
    run = 1'b0;
    wait_until(e + 12);
    chk("div2_busy", int'(busy), 0);
    chk("sb_empty3", sb.size(), 0);

    // Reset mid-high-phase with a configuration pending: the reset acts
    // immediately, and the pending value is discarded.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run = 1'b1;
    e = cyc + 1;
    push(1, e + 15, 14);
    wait_until(e + 18);
    cfg_half = 4'd5; cfg_valid = 1'b1;
    wait_until(e + 19);
    cfg_valid = 1'b0;
    chk("ar_pend", int'(cfg_ready), 0);
    wait_until(e + 22);
    chk("ar_hi", int'(div_clk), 1);
    rst_n = 1'b0; run = 1'b0;
    #1;
    chk("ar_div",  int'(div_clk), 0);
    chk("ar_half", int'(cur_half), 14);
    chk("ar_rdy",  int'(cfg_ready), 1);
    chk("ar_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run = 1'b1;
    e = cyc + 1;
    push(1, e + 15, 14); push(0, e + 30, 14);
    wait_until(e + 20);
    run = 1'b0;
    wait_until(e + 40);
    chk("ar_after_half", int'(cur_half), 14);
    chk("sb_empty4", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
